// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, stage state and immediate sign-extension shared by the execute stage
package alu_pkg;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SUBI  = 4'b0011;
    localparam logic [3:0] OP_LD    = 4'b0100;
    localparam logic [3:0] OP_ST    = 4'b0101;
    localparam logic [3:0] OP_EQ    = 4'b0110;
    localparam logic [3:0] OP_NE    = 4'b0111;
    localparam logic [3:0] OP_ADDS  = 4'b1000;
    localparam logic [3:0] OP_ADDIS = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1010;
    localparam logic [3:0] OP_MUL   = 4'b1011;
    localparam int SX_MAX_W = 64;
    typedef enum logic {IDLE, BUSY} state_e;
    function automatic logic [SX_MAX_W-1:0] sext(input logic [SX_MAX_W-1:0] v, input int w);
        logic [SX_MAX_W-1:0] m;
        m = {SX_MAX_W{1'b1}} << w;
        return v[6'(w - 1)] ? (v | m) : (v & ~m);
    endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one multiplier bit per cycle
module alu_mul_seq #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W:0]   acc;
    // the multiplier sits in the low half and shifts out as the product shifts in
    assign acc  = {1'b0, product[2*DATA_W-1:DATA_W]} + (product[0] ? {1'b0, mcand} : '0);
    assign done = busy && cnt == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            product <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= CNT_W'(DATA_W);
            mcand   <= a;
            product <= {{DATA_W{1'b0}}, b};
        end else if (done) begin
            busy    <= 1'b0;
        end else if (busy) begin
            cnt     <= cnt - CNT_W'(1);
            product <= {acc, product[DATA_W-1:1]};
        end
    end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: handshaked execute-stage ALU with a registered result slot
// Define ALU_MUL_EN to make opcode 1011 a multi-cycle unsigned multiply.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 4,
    parameter int REGDST_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          opcode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [IMM_W-1:0]    imm,
    input  logic [REGDST_W-1:0] regdst_in,
    input  logic [DATA_W-1:0]   rd2_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   alu_out,
    output logic                carry_out,
    output logic                zero_out,
    output logic                cmp_out,
    output logic [REGDST_W-1:0] regdst_out,
    output logic [DATA_W-1:0]   rd2_out,
    output logic [3:0]          opcode_out
);
    logic [DATA_W-1:0] sx, opnd, res, nxt_out;
    logic [DATA_W:0]   sum;
    logic              sub, cy, nxt_cy, accept, load_res;
    assign sx     = DATA_W'(sext(SX_MAX_W'(imm), IMM_W));
    assign accept = in_valid && in_ready;
    // subtraction is a + ~x + 1, so the adder carry reads as "no borrow"
    always_comb begin
        sub  = opcode == OP_SUB || opcode == OP_SUBI;
        opnd = b;
        case (opcode)
            OP_ADDI, OP_SUBI, OP_LD, OP_ST: opnd = sx;
            OP_ADDS:                        opnd = b << 2;
            OP_ADDIS, OP_JMP:               opnd = sx << 2;
            default:                        opnd = b;
        endcase
        sum = {1'b0, a} + {1'b0, sub ? ~opnd : opnd} + {{DATA_W{1'b0}}, sub};
        res = sum[DATA_W-1:0];
        cy  = sum[DATA_W];
        if (opcode == OP_EQ || opcode == OP_NE) begin
            res = DATA_W'((a == b) ^ (opcode == OP_NE));
            cy  = 1'b0;
        end
    end
`ifdef ALU_MUL_EN
    state_e              state, state_n;
    logic                is_mul, mul_done;
    logic [2*DATA_W-1:0] product;
    assign is_mul   = opcode == OP_MUL;
    assign in_ready = (!out_valid || out_ready) && state == IDLE;
    alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        if (state == IDLE && accept && is_mul) state_n = BUSY;
        if (state == BUSY && mul_done) state_n = IDLE;
    end
    assign nxt_out  = mul_done ? product[DATA_W-1:0] : res;
    assign nxt_cy   = mul_done ? |product[2*DATA_W-1:DATA_W] : cy;
    assign load_res = (accept && !is_mul) || mul_done;
`else
    assign in_ready = !out_valid || out_ready;
    assign nxt_out  = res;
    assign nxt_cy   = cy;
    assign load_res = accept;
`endif
    // sideband is captured at accept; accept only happens into an empty or retiring slot
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            alu_out    <= '0;
            carry_out  <= 1'b0;
            zero_out   <= 1'b0;
            cmp_out    <= 1'b0;
            regdst_out <= '0;
            rd2_out    <= '0;
            opcode_out <= '0;
        end else begin
            if (load_res) begin
                out_valid <= 1'b1;
                alu_out   <= nxt_out;
                carry_out <= nxt_cy;
                zero_out  <= nxt_out == '0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                cmp_out    <= a == b;
                regdst_out <= regdst_in;
                rd2_out    <= rd2_in;
                opcode_out <= opcode;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and randomized checks of alu_exec_stage against a behavioural model
module tb_alu_exec_stage;
    localparam int DW = 32, IW = 4, RW = 4;
    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, carry_out, zero_out, cmp_out;
    logic [3:0]    opcode, opcode_out;
    logic [DW-1:0] a, b, rd2_in, alu_out, rd2_out;
    logic [IW-1:0] imm;
    logic [RW-1:0] regdst_in, regdst_out;
    logic [RW-1:0] last_rd;
    logic [DW-1:0] last_rd2;
    int vectors = 0, miscompares = 0;
    typedef struct packed {
        logic [DW-1:0] res;
        logic          cy, zero, cmp;
        logic [RW-1:0] rd;
        logic [DW-1:0] rd2;
        logic [3:0]    op;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_exec_stage #(.DATA_W(DW), .IMM_W(IW), .REGDST_W(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .a(a), .b(b), .imm(imm), .regdst_in(regdst_in), .rd2_in(rd2_in),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .carry_out(carry_out),
        .zero_out(zero_out), .cmp_out(cmp_out), .regdst_out(regdst_out), .rd2_out(rd2_out),
        .opcode_out(opcode_out)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] x, y,
                                   input logic [IW-1:0] im, input logic [RW-1:0] rd,
                                   input logic [DW-1:0] r2);
        longint unsigned m, ua, ub, sx, s, d;
`ifdef ALU_MUL_EN
        longint unsigned full;
`endif
        logic [DW-1:0] r;
        logic          c;
        exp_t          e;
        m  = (64'd1 << DW) - 64'd1;
        ua = 64'(x);
        ub = 64'(y);
        sx = longint'($signed(im)) & m;
        s  = ua + ub;
        case (op)
            4'd1, 4'd4, 4'd5: s = ua + sx;
            4'd8:             s = ua + ((ub * 4) & m);
            4'd9, 4'd10:      s = ua + ((sx * 4) & m);
            default:          s = ua + ub;
        endcase
        r = DW'(s & m);
        c = ((s >> DW) & 64'd1) != 0;
        if (op == 4'd2 || op == 4'd3) begin
            d = (op == 4'd2) ? ub : sx;
            r = DW'((ua - d) & m);
            c = ua >= d;
        end
        if (op == 4'd6 || op == 4'd7) begin
            r = DW'((ua == ub) != (op == 4'd7));
            c = 1'b0;
        end
`ifdef ALU_MUL_EN
        if (op == 4'd11) begin
            full = ua * ub;
            r = DW'(full & m);
            c = (full >> DW) != 0;
        end
`endif
        e.res = r; e.cy = c; e.zero = r == '0; e.cmp = x == y;
        e.rd = rd; e.rd2 = r2; e.op = op;
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [DW-1:0] x, y, input logic [IW-1:0] im);
        opcode = op; a = x; b = y; imm = im;
        regdst_in = RW'($urandom); rd2_in = $urandom;
        last_rd = regdst_in; last_rd2 = rd2_in;
        in_valid = 1'b1;
    endtask

    task automatic one_op(input logic [3:0] op, input logic [DW-1:0] x, y, input logic [IW-1:0] im);
        @(negedge clk);
        drive(op, x, y, im);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; a = '0; b = '0;
        imm = '0; regdst_in = '0; rd2_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, alu_out, carry_out, zero_out, cmp_out, regdst_out, rd2_out, opcode_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b out=%h c=%b z=%b cmp=%b rd=%h rd2=%h op=%h, need all 0",
                     out_valid, alu_out, carry_out, zero_out, cmp_out, regdst_out, rd2_out, opcode_out);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_addi;
        one_op(4'b0001, 32'd10, $urandom, 4'hF);
        vectors++;
        if ({out_valid, alu_out, carry_out, zero_out, in_ready} !== {1'b1, 32'd9, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL addi: got v=%b out=%h c=%b z=%b rdy=%b need v=1 out=9 c=1 z=0 rdy=1",
                     out_valid, alu_out, carry_out, zero_out, in_ready);
        end
        vectors++;
        if ({regdst_out, rd2_out, opcode_out} !== {last_rd, last_rd2, 4'b0001}) begin
            miscompares++;
            $display("FAIL addi_sideband: got rd=%h rd2=%h op=%h need rd=%h rd2=%h op=1",
                     regdst_out, rd2_out, opcode_out, last_rd, last_rd2);
        end
    endtask

    task automatic test_sub_cmp;
        one_op(4'b0010, 32'd3, 32'd5, 4'h0);
        vectors++;
        if ({alu_out, carry_out, zero_out, cmp_out} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_neg: got out=%h c=%b z=%b cmp=%b need out=fffffffe c=0 z=0 cmp=0",
                     alu_out, carry_out, zero_out, cmp_out);
        end
        one_op(4'b0010, 32'd7, 32'd7, 4'h3);
        vectors++;
        if ({alu_out, carry_out, zero_out, cmp_out} !== {32'd0, 1'b1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_eq: got out=%h c=%b z=%b cmp=%b need out=0 c=1 z=1 cmp=1",
                     alu_out, carry_out, zero_out, cmp_out);
        end
        one_op(4'b1101, 32'd5, 32'd5, 4'h0);
        vectors++;
        if ({alu_out, cmp_out} !== {32'd10, 1'b1}) begin
            miscompares++;
            $display("FAIL cmp_any_op: got out=%h cmp=%b need out=a cmp=1", alu_out, cmp_out);
        end
        one_op(4'b0110, 32'd4, 32'd4, 4'h0);
        vectors++;
        if ({alu_out, carry_out} !== {32'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL seteq: got out=%h c=%b need out=1 c=0", alu_out, carry_out);
        end
        one_op(4'b0111, 32'hFFFF_FFFF, 32'd5, 4'h0);
        vectors++;
        if ({alu_out, carry_out, cmp_out} !== {32'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL setne: got out=%h c=%b cmp=%b need out=1 c=0 cmp=0", alu_out, carry_out, cmp_out);
        end
    endtask

    task automatic test_shifted;
        one_op(4'b1001, 32'd100, $urandom, 4'hE);
        vectors++;
        if (alu_out !== 32'd92) begin
            miscompares++;
            $display("FAIL addis_neg: got %0d need 92", alu_out);
        end
        one_op(4'b1010, 32'd0, $urandom, 4'h1);
        vectors++;
        if (alu_out !== 32'd4) begin
            miscompares++;
            $display("FAIL jump: got %0d need 4", alu_out);
        end
        one_op(4'b1000, 32'd1, 32'd3, 4'h0);
        vectors++;
        if (alu_out !== 32'd13) begin
            miscompares++;
            $display("FAIL adds: got %0d need 13", alu_out);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(4'b0000, 32'd20, 32'd22, 4'h0);
        out_ready = 1'b0;
        @(negedge clk);
        drive(4'b0011, 32'd50, $urandom, 4'h2);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({out_valid, in_ready, alu_out, opcode_out} !== {1'b1, 1'b0, 32'd42, 4'b0000}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b rdy=%b out=%0d op=%h need v=1 rdy=0 out=42 op=0",
                         i, out_valid, in_ready, alu_out, opcode_out);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: got %b need 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, alu_out, opcode_out, rd2_out} !== {1'b1, 32'd48, 4'b0011, last_rd2}) begin
            miscompares++;
            $display("FAIL no_bubble: got v=%b out=%0d op=%h rd2=%h need v=1 out=48 op=3 rd2=%h",
                     out_valid, alu_out, opcode_out, rd2_out, last_rd2);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL no_duplicate: got v=%b need 0", out_valid);
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul;
        bit seen;
        @(negedge clk);
        drive(4'b1011, 32'h1_0000, 32'h1_0000, 4'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            vectors++;
            if ({out_valid, in_ready} !== 2'b00) begin
                miscompares++;
                $display("FAIL mul_busy[%0d]: got v=%b rdy=%b need 0 0", k, out_valid, in_ready);
            end
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, alu_out, carry_out, zero_out} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL mul_result: got v=%b out=%h c=%b z=%b need v=1 out=0 c=1 z=1",
                     out_valid, alu_out, carry_out, zero_out);
        end
        @(negedge clk);
        drive(4'b1011, $urandom, $urandom, 4'h0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_abort_ready: got %b need 1", in_ready);
        end
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL mul_abort_valid: got out_valid=1 after reset need 0");
        end
    endtask
`endif

    task automatic test_random;
        exp_t got;
        bit acc, ret;
        logic [DW-1:0] x, y;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            y = ($urandom_range(0, 3) == 0) ? x : $urandom;
            drive(4'($urandom_range(0, 15)), x, y, 4'($urandom));
            in_valid = ($urandom_range(0, 9) < 7);
            #1;
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            if (ret) begin
                got = {alu_out, carry_out, zero_out, cmp_out, regdst_out, rd2_out, opcode_out};
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra: retired %h with nothing outstanding", got);
                end else begin
                    if (got !== q[0]) begin
                        miscompares++;
                        $display("FAIL rand_result cyc %0d: got %h need %h", cyc, got, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (acc) q.push_back(model(opcode, a, b, imm, regdst_in, rd2_in));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) begin
            #1;
            if (out_valid) begin
                got = {alu_out, carry_out, zero_out, cmp_out, regdst_out, rd2_out, opcode_out};
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL drain_extra: retired %h with nothing outstanding", got);
                end else begin
                    if (got !== q[0]) begin
                        miscompares++;
                        $display("FAIL drain_result: got %h need %h", got, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_lost: %0d results never retired, need 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_cmp();
        test_shifted();
        test_back_to_back();
`ifdef ALU_MUL_EN
        test_mul();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
